round_const_seq: RTL
====================

Name: round_const_seq

Overview:
- Parametrised round-constant sequencer for the hash cores.
- Serves both SHA-256 and SHA-512 from one 80-entry 64-bit K table. SHA-256 K[i] equals the upper 32 bits of SHA-512 K[i] for i<64.
- Emits UNROLL consecutive constants per beat over a valid/ready stream to the compression round engine.
- Replaces direct combinational K lookup: the round engine no longer tracks the round index for constants.

Parameters:
- UNROLL, 1: constants per beat. Legal values 1, 2, 4 (divide both 64 and 80).
- IDX_W, 7: round index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a sequence. Accepted only in IDLE.
- mode  in  1  0=SHA-256 (64 rounds), 1=SHA-512 (80 rounds). Sampled on accepted start.
- abort  in  1  terminate the current sequence
- kt_ready  in  1  consumer accepts the beat
- kt_valid  out  1  beat valid
- kt  out  64*UNROLL  lane j = kt[64*j +: 64] = constant for round round_idx+j
- round_idx  out  IDX_W  round index of lane 0
- last  out  1  current beat holds the final round
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the final beat handshakes

Behaviour:
- Reset (async, any state): state=IDLE. kt_valid, last, busy, done = 0. kt = 0, round_idx = 0, mode register = 0.
- N = 64 (mode 0) or 80 (mode 1). Beats per sequence = N/UNROLL.
- Lane value:
  - mode 1: K512[r].
  - mode 0: {32'h0, K512[r][63:32]}.
- States:
  - IDLE: start=1 and abort=0 -> latch mode, load beat 0 into output registers, go RUN. kt_valid=1 on the next cycle (latency 1). start with abort in the same cycle is ignored.
  - RUN: output registers load when (!kt_valid || kt_ready).
    - Handshake on a non-last beat -> next beat (round_idx += UNROLL) appears the following cycle. Full throughput is one beat per cycle with kt_ready held high.
    - Handshake on the last beat -> kt_valid=0, go DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Backpressure: while kt_valid=1 and kt_ready=0, kt, round_idx and last hold stable.
- last = kt_valid && (round_idx == N-UNROLL).
- abort in RUN (any ready/valid state): next cycle state=IDLE, kt_valid=0, last=0, no done pulse. A handshake in the same cycle as abort is not counted.
- start, and changes to mode, while busy are ignored. The latched mode governs the whole sequence.
- round_idx never exceeds N-UNROLL; there is no wrap. kt retains its last value in IDLE; consumers qualify with kt_valid.
- Output registers and counter are flops; the ROM lookup is combinational on the next index. Index computation uses IDX_W+1 bits, so 80 is never aliased.

Decomposition:
- Package hash_const_pkg holds:
  - localparam K512 table [0:79] of 64-bit values
  - mode enum (MODE_SHA256, MODE_SHA512)
  - state enum (IDLE, RUN, DONE)
  - ROUNDS_256=64, ROUNDS_512=80
- Sub-module round_const_rom: combinational, inputs idx[6:0] and mode, output the 64-bit lane value. Instantiated UNROLL times, with idx+j per lane.

Test Plan:
- UNROLL=1, mode=1, kt_ready=1, start pulse:
  - cycle+1: kt=64'h428a2f98d728ae22, round_idx=0.
  - 80 consecutive beats; beat 79: kt=64'h6c44198c4a475817 with last=1.
  - done=1 the cycle after the last beat; busy falls the cycle after done.
- UNROLL=1, mode=0:
  - beat 0: kt=64'h00000000428a2f98.
  - beat 63: kt=64'h00000000c67178f2, last=1.
  - exactly 64 beats, done follows.
- Backpressure, mode=1: drop kt_ready for 5 cycles at round_idx=10 -> kt holds 64'h243185be4ee4b28c. Resume -> round_idx=11 (64'h550c7dc3d5ffb4e2) with no skip or duplicate.
- UNROLL=4, mode=1:
  - beat 0 lanes = 428a2f98d728ae22, 7137449123ef65cd, b5c0fbcfec4d3b2f, e9b5dba58189dbbc.
  - 20 beats total; last on round_idx=76.
- Abort at round_idx=30 -> kt_valid=0 next cycle, no done pulse. A fresh start then resumes from round_idx=0 in the new mode.
- Reset asserted mid-RUN asynchronously -> all outputs 0 immediately. Start ignored while busy; start during DONE ignored.

Source files
------------

// File: rtl/round_const_seq_pkg.sv
// Shared constants for the SHA-2 round-constant sequencer: the 80-entry SHA-512 K table,
// the mode and state encodings, and the lane formatting rule.
package hash_const_pkg;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  typedef enum logic {
    MODE_SHA256 = 1'b0,
    MODE_SHA512 = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [63:0] K512 [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // SHA-256 K[i] is the upper word of SHA-512 K[i], zero-extended into the 64-bit lane
  function automatic logic [63:0] lane_value(input logic [63:0] k, input mode_e m);
    return (m == MODE_SHA512) ? k : {32'h0000_0000, k[63:32]};
  endfunction

endpackage

// File: rtl/round_const_rom.sv
// Combinational K lookup for one lane; indices beyond the table read as zero.
module round_const_rom
  import hash_const_pkg::*;
(
  input  logic [6:0]  idx,
  input  logic        mode,
  output logic [63:0] k
);

  // Table read with lane formatting for the selected hash width
  always_comb begin
    k = 64'h0;
    if (idx < 7'(ROUNDS_512)) begin
      k = lane_value(K512[idx], mode_e'(mode));
    end else begin
      k = 64'h0;
    end
  end

endmodule

// File: rtl/round_const_seq.sv
// Round-constant sequencer: streams UNROLL consecutive K values per beat over valid/ready
// for a 64-round (SHA-256) or 80-round (SHA-512) sequence.
module round_const_seq
  import hash_const_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int IDX_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  input  logic                  kt_ready,
  output logic                  kt_valid,
  output logic [64*UNROLL-1:0]  kt,
  output logic [IDX_W-1:0]      round_idx,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  // One extra bit keeps the round count of 80 representable in index arithmetic
  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] STEP = CW'(UNROLL);

  state_e                 state_r;
  state_e                 state_nx_s;
  mode_e                  mode_r;
  mode_e                  rom_mode_s;
  logic [IDX_W-1:0]       idx_r;
  logic [64*UNROLL-1:0]   kt_r;
  logic [64*UNROLL-1:0]   kt_nx_s;
  logic                   kt_valid_r;
  logic                   last_r;
  logic                   hs_s;
  logic                   launch_s;
  logic [CW-1:0]          base_s;
  logic [CW-1:0]          last_idx_s;
  logic [6:0]             lane_idx_s [UNROLL];

  assign hs_s     = kt_valid_r & kt_ready;
  assign launch_s = (state_r == IDLE) & start & ~abort;

  // Candidate next beat: beat 0 of a fresh sequence in IDLE, otherwise the successor beat
  always_comb begin
    rom_mode_s = mode_r;
    base_s     = {1'b0, idx_r} + STEP;
    if (state_r == IDLE) begin
      rom_mode_s = mode_e'(mode);
      base_s     = {CW{1'b0}};
    end else begin
      rom_mode_s = mode_r;
      base_s     = {1'b0, idx_r} + STEP;
    end
    last_idx_s = ((rom_mode_s == MODE_SHA512) ? CW'(ROUNDS_512) : CW'(ROUNDS_256)) - STEP;
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_lane
    assign lane_idx_s[j] = 7'(base_s + CW'(j));

    round_const_rom u_rom (
      .idx  (lane_idx_s[j]),
      .mode (rom_mode_s),
      .k    (kt_nx_s[64*j +: 64])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; abort takes priority over a same-cycle handshake
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) state_nx_s = RUN;
        else          state_nx_s = IDLE;
      end
      RUN: begin
        if (abort)                 state_nx_s = IDLE;
        else if (hs_s && last_r)   state_nx_s = DONE;
        else                       state_nx_s = RUN;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Beat registers: load on launch or on a non-final handshake, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r     <= MODE_SHA256;
      idx_r      <= {IDX_W{1'b0}};
      kt_r       <= {(64*UNROLL){1'b0}};
      kt_valid_r <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            mode_r     <= mode_e'(mode);
            idx_r      <= base_s[IDX_W-1:0];
            kt_r       <= kt_nx_s;
            kt_valid_r <= 1'b1;
            last_r     <= (base_s == last_idx_s);
          end
        end
        RUN: begin
          if (abort || (hs_s && last_r)) begin
            kt_valid_r <= 1'b0;
            last_r     <= 1'b0;
          end else if (hs_s) begin
            idx_r  <= base_s[IDX_W-1:0];
            kt_r   <= kt_nx_s;
            last_r <= (base_s == last_idx_s);
          end
        end
        DONE: begin
          kt_valid_r <= 1'b0;
          last_r     <= 1'b0;
        end
        default: begin
          kt_valid_r <= 1'b0;
          last_r     <= 1'b0;
        end
      endcase
    end
  end

  // Status decode from the state register
  always_comb begin
    busy = (state_r != IDLE);
    done = (state_r == DONE);
  end

  assign kt_valid  = kt_valid_r;
  assign kt        = kt_r;
  assign round_idx = idx_r;
  assign last      = last_r;

endmodule
